// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Constants and types shared by the line-interface memory responder and the
// cache controllers that talk to it over the m_* interface.
//   LINE_ADDR_W / LINE_W / MEM_LATENCY : default geometry and response latency
//   MEM_IDLE / MEM_BUSY / MEM_READY    : responder state encodings
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int LINE_ADDR_W = 14;
    localparam int LINE_W      = 64;
    localparam int MEM_LATENCY = 4;

    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_BUSY  = 2'b01;
    localparam logic [1:0] MEM_READY = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = MEM_IDLE,
        ST_BUSY  = MEM_BUSY,
        ST_READY = MEM_READY
    } mem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

endpackage

// File: rtl/line_mem_array.sv
// ---------------------------------------------------------------------------
// line_mem_array
// Single-port line store: synchronous write, synchronous read. The read
// register only loads on `re`, so it holds the last line read until the next
// read; it is the responder's m_rd_data.
// Ports:
//   clk, rst : clock, synchronous active-high reset (read register only)
//   we       : write wdata to addr at the next rising edge
//   re       : load mem[addr] into rdata at the next rising edge
//   addr     : line address
//   wdata    : write line
//   rdata    : registered read line
// ---------------------------------------------------------------------------
module line_mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int DATA_W = LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Storage is deliberately not cleared by reset.
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Whole-line write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register: cleared by reset, loaded only on a read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/unified_mem_responder.sv
// ---------------------------------------------------------------------------
// unified_mem_responder
// Backing-store responder for the cache line interface. Accepts one line read
// or write, waits a fixed LATENCY cycles and answers with a one-cycle m_rdy.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   m_re, m_we : read / write request levels (write wins when both high)
//   m_addr     : line address, captured at acceptance
//   m_wr_data  : write line, captured at acceptance
//   m_rd_data  : read line, valid from the m_rdy cycle of a read until the
//                next read completes
//   m_rdy      : one-cycle completion pulse for reads and writes
//   m_busy     : high from acceptance through the m_rdy cycle
// LATENCY must lie in 2..15 (the 4-bit counter loads LATENCY-2).
// ---------------------------------------------------------------------------
module unified_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = LINE_ADDR_W,
    parameter int DATA_W  = LINE_W,
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_re,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wr_data,
    output logic [DATA_W-1:0] m_rd_data,
    output logic              m_rdy,
    output logic              m_busy
);

    // One BUSY cycle is spent with cnt at each value LATENCY-2 .. 0, then
    // READY follows, which puts m_rdy exactly LATENCY cycles after acceptance.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    mem_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    mem_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              m_rdy_q, m_rdy_d;
    logic              m_busy_q, m_busy_d;
    logic              mem_we_s;
    logic              mem_re_s;
    logic [DATA_W-1:0] mem_rdata_s;

    // State, counter, request latches and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            op_q     <= OP_READ;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            m_rdy_q  <= 1'b0;
            m_busy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            m_rdy_q  <= m_rdy_d;
            m_busy_q <= m_busy_d;
        end
    end

    // Next-state logic: acceptance in IDLE, countdown in BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (m_we || m_re) begin
                    // Write has priority; a simultaneous read is dropped.
                    op_d    = m_we ? OP_WRITE : OP_READ;
                    addr_d  = m_addr;
                    wdata_d = m_wr_data;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_READY: begin
                // Requests are ignored here so a requester that drops on
                // m_rdy cannot be accepted twice.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs: array strobes on the BUSY->READY transition, plus the values
    // m_rdy / m_busy take in the next cycle.
    always_comb begin
        mem_we_s = 1'b0;
        mem_re_s = 1'b0;
        m_rdy_d  = (state_d == ST_READY);
        m_busy_d = (state_d != ST_IDLE);
        if (rst) begin
            // A reset on the commit edge must discard the in-flight write.
            mem_we_s = 1'b0;
            mem_re_s = 1'b0;
        end else if ((state_q == ST_BUSY) && (cnt_q == 4'd0)) begin
            mem_we_s = (op_q == OP_WRITE);
            mem_re_s = (op_q == OP_READ);
        end else begin
            mem_we_s = 1'b0;
            mem_re_s = 1'b0;
        end
    end

    line_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata_s)
    );

    assign m_rd_data = mem_rdata_s;
    assign m_rdy     = m_rdy_q;
    assign m_busy    = m_busy_q;

endmodule
